seq_det_param: RTL

- Parametrised Moore serial sequence detector; next generation of the fixed 3-bit-state detector.
- Pattern, pattern length, overlap mode and match-counter width are all parameters.
- The transition table is derived at elaboration from a prefix-function (KMP) over PATTERN.
- Adds an input enable, a saturating match counter with synchronous clear, and an exposed state for debug. Sits directly on a serial bit stream.

---
 rtl/seq_det_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_det_param.sv
// Parametrised Moore serial sequence detector with a KMP-derived transition table,
// input enable, saturating match counter and exposed state index.
module seq_det_param #(
   parameter int unsigned PAT_W   = 4,
   parameter logic [15:0] PATTERN = 16'b1101,
   parameter bit          OVERLAP = 1'b1,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned SW      = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seq_in,
   input  logic             clr_cnt,
   output logic             det_out,
   output logic [SW-1:0]    state_out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam logic [SW-1:0] S_IDLE = '0;
   localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

   // Table is padded to every encodable state so unreachable codes still index safely.
   localparam int unsigned ROWS  = 2 ** SW;
   localparam int unsigned TBL_W = ROWS * 2 * SW;

   // i-th received pattern bit (MSB of the truncated pattern first).
   function automatic logic pat_bit(input int unsigned i);
      return PATTERN[4'(PAT_W - 1 - i)];
   endfunction

   // Prefix function: longest proper border of the first len pattern bits.
   function automatic int unsigned border(input int unsigned len);
      int unsigned res;
      logic        found;
      logic        ok;
      res   = 0;
      found = 1'b0;
      for (int b = int'(len) - 1; b >= 1; b--) begin
         ok = 1'b1;
         for (int j = 0; j < b; j++) begin
            if (pat_bit(j) != pat_bit(len - b + j)) ok = 1'b0;
         end
         if (ok && !found) begin
            res   = b;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Advance from prefix length k on bit b, falling back along the border chain.
   function automatic int unsigned step_from(input int unsigned k, input logic b);
      int unsigned j;
      int unsigned res;
      logic        done;
      j    = k;
      res  = 0;
      done = 1'b0;
      for (int it = 0; it <= 16; it++) begin
         if (!done) begin
            if (j < PAT_W && pat_bit(j) == b) begin
               res  = j + 1;
               done = 1'b1;
            end else if (j == 0) begin
               res  = 0;
               done = 1'b1;
            end else begin
               j = border(j);
            end
         end
      end
      return res;
   endfunction

   function automatic logic [TBL_W-1:0] build_tbl();
      logic [TBL_W-1:0] t;
      int unsigned      kk;
      t = '0;
      for (int unsigned k = 0; k <= PAT_W; k++) begin
         for (int b = 0; b < 2; b++) begin
            if (k == PAT_W) kk = OVERLAP ? border(PAT_W) : 0;
            else            kk = k;
            t = t | (TBL_W'(step_from(kk, b[0])) << ((k * 2 + unsigned'(b)) * SW));
         end
      end
      return t;
   endfunction

   localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

   logic [SW-1:0]    state_q, state_d, next_state;
   logic             det_q, det_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW:0]      row;

   always_comb begin
      row        = {state_q, seq_in};
      next_state = SW'(NEXT_TBL >> (32'(row) * SW));
      state_d    = en ? next_state : state_q;
      det_d      = (state_d == S_FULL);
      cnt_d      = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (en && next_state == S_FULL && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         det_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         cnt_q   <= cnt_d;
      end
   end

   assign det_out   = det_q;
   assign state_out = state_q;
   assign match_cnt = cnt_q;

endmodule
